// File: rtl/int_rx_pkg.sv
// Shared types and constants for the ASCII expression front end that feeds the ALU.
package int_rx_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_A     = 3'd1,
      S_OP    = 3'd2,
      S_B     = 3'd3,
      S_EXEC  = 3'd4,
      S_SEND  = 3'd5,
      S_ERROR = 3'd6
   } state_e;

   localparam logic [5:0] OP_ADD = 6'h20;
   localparam logic [5:0] OP_SRL = 6'h21;
   localparam logic [5:0] OP_SUB = 6'h22;
   localparam logic [5:0] OP_SRA = 6'h23;
   localparam logic [5:0] OP_AND = 6'h24;
   localparam logic [5:0] OP_OR  = 6'h25;
   localparam logic [5:0] OP_XOR = 6'h26;
   localparam logic [5:0] OP_NOR = 6'h27;

   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_MINUS = 8'h2D;
   localparam logic [7:0] CH_PLUS  = 8'h2B;
   localparam logic [7:0] CH_GT    = 8'h3E;
   localparam logic [7:0] CH_QUEST = 8'h3F;
   localparam logic [7:0] CH_AMP   = 8'h26;
   localparam logic [7:0] CH_CARET = 8'h5E;
   localparam logic [7:0] CH_X     = 8'h78;
   localparam logic [7:0] CH_TILDE = 8'h7E;

   localparam logic [1:0] ERR_NONE   = 2'd0;
   localparam logic [1:0] ERR_CHAR   = 2'd1;
   localparam logic [1:0] ERR_OVF    = 2'd2;
   localparam logic [1:0] ERR_DIGITS = 2'd3;

   function automatic logic is_digit(input logic [7:0] c);
      return (c >= 8'h30) && (c <= 8'h39);
   endfunction

   // Returns {valid, opcode}; '-' is only an operator once operand A has digits.
   function automatic logic [6:0] op_decode(input logic [7:0] c);
      case (c)
         CH_PLUS:  return {1'b1, OP_ADD};
         CH_GT:    return {1'b1, OP_SRL};
         CH_MINUS: return {1'b1, OP_SUB};
         CH_QUEST: return {1'b1, OP_SRA};
         CH_AMP:   return {1'b1, OP_AND};
         CH_CARET: return {1'b1, OP_OR};
         CH_X:     return {1'b1, OP_XOR};
         CH_TILDE: return {1'b1, OP_NOR};
         default:  return 7'd0;
      endcase
   endfunction

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

endpackage

// File: rtl/int_rx_alu_ctrl_hex_tx_serializer.sv
// Streams a result as uppercase hex (MSB nibble first) followed by CR LF into the TX FIFO.
module hex_tx_serializer
   import int_rx_pkg::*;
#(
   parameter int NBIT = 8
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic [NBIT-1:0] res,
   input  logic            start,
   input  logic            TX_FULL,
   output logic            WR_TX,
   output logic [7:0]      TX_DATA,
   output logic            done
);

   localparam int NHEX = NBIT / 4;
   localparam int NCHR = NHEX + 2;
   localparam int IW   = $clog2(NCHR);

   logic [IW-1:0] idx;
   logic          active;
   logic [3:0]    nib;
   logic [7:0]    ch;

   always_comb begin
      nib = 4'h0;
      for (int k = 0; k < NHEX; k++) begin
         if (idx == IW'(k)) nib = res[4*(NHEX-1-k) +: 4];
      end
      if (idx == IW'(NCHR - 2))      ch = CH_CR;
      else if (idx == IW'(NCHR - 1)) ch = CH_LF;
      else                           ch = hex_char(nib);
   end

   // The index only moves on an accepted write, so TX_DATA holds while TX_FULL stalls.
   assign WR_TX   = active & ~TX_FULL;
   assign TX_DATA = active ? ch : 8'h00;
   assign done    = WR_TX && (idx == IW'(NCHR - 1));

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         idx    <= '0;
         active <= 1'b0;
      end else if (start) begin
         idx    <= '0;
         active <= 1'b1;
      end else if (WR_TX) begin
         if (done) begin
            idx    <= '0;
            active <= 1'b0;
         end else begin
            idx <= idx + IW'(1);
         end
      end
   end

endmodule

// File: rtl/int_rx_alu_ctrl.sv
// Parses "[-]A op [-]B<CR>" from the RX FIFO, runs it through the ALU and returns the hex result.
// Handshakes: RD_RX pops the FWFT RX head in the same cycle it is high (never while RX_EMPTY);
// WR_TX pushes TX_DATA in the cycle it is high (never while TX_FULL).
module int_rx_alu_ctrl
   import int_rx_pkg::*;
#(
   parameter int NBIT       = 8,
   parameter int MAX_DIGITS = 3,
   parameter int OPW        = 6
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            RX_EMPTY,
   input  logic [7:0]      RX_DATA,
   output logic            RD_RX,
   input  logic            TX_FULL,
   output logic [7:0]      TX_DATA,
   output logic            WR_TX,
   output logic [NBIT-1:0] ALU_A,
   output logic [NBIT-1:0] ALU_B,
   output logic [OPW-1:0]  ALU_OP,
   input  logic [NBIT-1:0] ALU_RESULT,
   output logic            BUSY,
   output logic            DONE,
   output logic            ERR,
   output logic [1:0]      ERR_CODE,
   output state_e          DBG_STATE
);

   localparam int AW  = NBIT + 4;
   localparam int NDW = $clog2(MAX_DIGITS + 1);

   state_e          state, state_n;
   logic [AW-1:0]   acc, acc_n;
   logic [NDW-1:0]  ndig, ndig_n;
   logic            neg_a, neg_a_n;
   logic            neg_b, neg_b_n;
   logic [NBIT-1:0] alu_a, alu_a_n;
   logic [NBIT-1:0] alu_b, alu_b_n;
   logic [OPW-1:0]  alu_op, alu_op_n;
   logic [NBIT-1:0] res, res_n;
   logic [1:0]      err_code, err_code_n;
   logic            done_r, done_n;
   logic            rd;
   logic            ser_start;
   logic            ser_done;

   logic            is_dig;
   logic [3:0]      dval;
   logic [6:0]      op_dec;
   logic [AW-1:0]   acc_x10d;
   logic            too_many;
   logic            ovf;
   logic [NBIT-1:0] mag;
   logic [NBIT-1:0] mag_neg;

   assign is_dig   = is_digit(RX_DATA);
   assign dval     = RX_DATA[3:0];
   assign op_dec   = op_decode(RX_DATA);
   // acc never exceeds 2^NBIT-1, so acc*10+9 always fits in NBIT+4 bits.
   assign acc_x10d = (acc << 3) + (acc << 1) + AW'(dval);
   assign too_many = (ndig == NDW'(MAX_DIGITS));
   assign ovf      = (acc_x10d[AW-1:NBIT] != '0);
   assign mag      = acc[NBIT-1:0];
   assign mag_neg  = (~mag) + NBIT'(1);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state    <= S_IDLE;
         acc      <= '0;
         ndig     <= '0;
         neg_a    <= 1'b0;
         neg_b    <= 1'b0;
         alu_a    <= '0;
         alu_b    <= '0;
         alu_op   <= OPW'(OP_ADD);
         res      <= '0;
         err_code <= ERR_NONE;
         done_r   <= 1'b0;
      end else begin
         state    <= state_n;
         acc      <= acc_n;
         ndig     <= ndig_n;
         neg_a    <= neg_a_n;
         neg_b    <= neg_b_n;
         alu_a    <= alu_a_n;
         alu_b    <= alu_b_n;
         alu_op   <= alu_op_n;
         res      <= res_n;
         err_code <= err_code_n;
         done_r   <= done_n;
      end
   end

   always_comb begin
      state_n    = state;
      acc_n      = acc;
      ndig_n     = ndig;
      neg_a_n    = neg_a;
      neg_b_n    = neg_b;
      alu_a_n    = alu_a;
      alu_b_n    = alu_b;
      alu_op_n   = alu_op;
      res_n      = res;
      err_code_n = err_code;
      done_n     = 1'b0;
      ser_start  = 1'b0;
      rd         = 1'b0;

      case (state)
         S_IDLE: begin
            if (!RX_EMPTY) begin
               rd = 1'b1;
               if (is_dig) begin
                  acc_n   = AW'(dval);
                  ndig_n  = NDW'(1);
                  state_n = S_A;
               end else if (RX_DATA == CH_MINUS) begin
                  neg_a_n = 1'b1;
               end else if (RX_DATA != CH_SPACE && RX_DATA != CH_CR) begin
                  err_code_n = ERR_CHAR;
                  state_n    = S_ERROR;
               end
            end
         end

         S_A, S_B: begin
            if (!RX_EMPTY) begin
               rd = 1'b1;
               if (is_dig) begin
                  // Digit-count limit takes precedence over the magnitude check.
                  if (too_many) begin
                     err_code_n = ERR_DIGITS;
                     state_n    = S_ERROR;
                  end else if (ovf) begin
                     err_code_n = ERR_OVF;
                     state_n    = S_ERROR;
                  end else begin
                     acc_n  = acc_x10d;
                     ndig_n = ndig + NDW'(1);
                  end
               end else if (state == S_A && op_dec[6] && ndig != '0) begin
                  alu_a_n  = neg_a ? mag_neg : mag;
                  alu_op_n = OPW'(op_dec[5:0]);
                  acc_n    = '0;
                  ndig_n   = '0;
                  state_n  = S_OP;
               end else if (state == S_B && RX_DATA == CH_CR && ndig != '0) begin
                  alu_b_n = neg_b ? mag_neg : mag;
                  state_n = S_EXEC;
               end else if (RX_DATA != CH_SPACE) begin
                  err_code_n = ERR_CHAR;
                  state_n    = S_ERROR;
               end
            end
         end

         S_OP: begin
            if (!RX_EMPTY) begin
               rd = 1'b1;
               if (is_dig) begin
                  acc_n   = AW'(dval);
                  ndig_n  = NDW'(1);
                  state_n = S_B;
               end else if (RX_DATA == CH_MINUS && ndig == '0) begin
                  neg_b_n = 1'b1;
               end else if (RX_DATA != CH_SPACE) begin
                  err_code_n = ERR_CHAR;
                  state_n    = S_ERROR;
               end
            end
         end

         S_EXEC: begin
            res_n     = ALU_RESULT;
            ser_start = 1'b1;
            state_n   = S_SEND;
         end

         S_SEND: begin
            if (ser_done) begin
               done_n     = 1'b1;
               err_code_n = ERR_NONE;
               neg_a_n    = 1'b0;
               neg_b_n    = 1'b0;
               acc_n      = '0;
               ndig_n     = '0;
               state_n    = S_IDLE;
            end
         end

         S_ERROR: begin
            if (!RX_EMPTY) begin
               rd = 1'b1;
               if (RX_DATA == CH_CR) begin
                  acc_n   = '0;
                  ndig_n  = '0;
                  neg_a_n = 1'b0;
                  neg_b_n = 1'b0;
                  state_n = S_IDLE;
               end
            end
         end

         default: state_n = S_IDLE;
      endcase
   end

   hex_tx_serializer #(
      .NBIT (NBIT)
   ) u_ser (
      .CLK     (CLK),
      .RESET   (RESET),
      .res     (res),
      .start   (ser_start),
      .TX_FULL (TX_FULL),
      .WR_TX   (WR_TX),
      .TX_DATA (TX_DATA),
      .done    (ser_done)
   );

   assign RD_RX     = rd;
   assign ALU_A     = alu_a;
   assign ALU_B     = alu_b;
   assign ALU_OP    = alu_op;
   assign BUSY      = (state != S_IDLE);
   assign DONE      = done_r;
   assign ERR       = (state == S_ERROR);
   assign ERR_CODE  = err_code;
   assign DBG_STATE = state;

endmodule

// File: tb/tb_int_rx_alu_ctrl.sv
// Bench for int_rx_alu_ctrl: directed scenarios plus randomized expressions against a line-level model.
module tb_int_rx_alu_ctrl;

   localparam int NBIT       = 8;
   localparam int MAX_DIGITS = 3;
   localparam int OPW        = 6;
   localparam int NHEX       = NBIT / 4;

   logic            CLK = 1'b0;
   logic            RESET = 1'b1;
   logic            RX_EMPTY = 1'b1;
   logic [7:0]      RX_DATA = 8'h00;
   logic            RD_RX;
   logic            TX_FULL = 1'b0;
   logic [7:0]      TX_DATA;
   logic            WR_TX;
   logic [NBIT-1:0] ALU_A;
   logic [NBIT-1:0] ALU_B;
   logic [OPW-1:0]  ALU_OP;
   logic [NBIT-1:0] ALU_RESULT;
   logic            BUSY;
   logic            DONE;
   logic            ERR;
   logic [1:0]      ERR_CODE;
   logic [2:0]      dbg_state;

   int n_vec  = 0;
   int n_miss = 0;

   logic [7:0] rx_q[$];
   logic [7:0] tx_got[$];
   logic [7:0] exp_q[$];
   logic [7:0] line_q[$];

   int   cyc = 0;
   int   cr_cyc = 0;
   int   done_cyc = 0;
   int   done_cnt = 0;
   int   n_done_exp = 0;
   int   d0 = 0;
   int   rd_viol = 0;
   int   wr_viol = 0;
   logic err_seen = 1'b0;
   logic rx_gaps = 1'b0;
   logic tx_bp = 1'b0;
   logic tx_full_force = 1'b0;
   logic wr_s = 1'b0;
   logic [7:0] txd_s = 8'h00;

   logic [7:0] op_ch [8] = '{8'h2B, 8'h3E, 8'h2D, 8'h3F, 8'h26, 8'h5E, 8'h78, 8'h7E};
   logic [7:0] bad_ch[5] = '{8'h23, 8'h21, 8'h3D, 8'h61, 8'h2E};

   always #5 CLK = ~CLK;

   int_rx_alu_ctrl #(
      .NBIT       (NBIT),
      .MAX_DIGITS (MAX_DIGITS),
      .OPW        (OPW)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .RX_EMPTY   (RX_EMPTY),
      .RX_DATA    (RX_DATA),
      .RD_RX      (RD_RX),
      .TX_FULL    (TX_FULL),
      .TX_DATA    (TX_DATA),
      .WR_TX      (WR_TX),
      .ALU_A      (ALU_A),
      .ALU_B      (ALU_B),
      .ALU_OP     (ALU_OP),
      .ALU_RESULT (ALU_RESULT),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .ERR        (ERR),
      .ERR_CODE   (ERR_CODE),
      .DBG_STATE  (dbg_state)
   );

   // Environment ALU: combinational result seen by the DUT.
   always_comb begin
      case (ALU_OP)
         6'h20:   ALU_RESULT = ALU_A + ALU_B;
         6'h21:   ALU_RESULT = ALU_A >> ALU_B[2:0];
         6'h22:   ALU_RESULT = ALU_A - ALU_B;
         6'h23:   ALU_RESULT = $signed(ALU_A) >>> ALU_B[2:0];
         6'h24:   ALU_RESULT = ALU_A & ALU_B;
         6'h25:   ALU_RESULT = ALU_A | ALU_B;
         6'h26:   ALU_RESULT = ALU_A ^ ALU_B;
         6'h27:   ALU_RESULT = ~(ALU_A | ALU_B);
         default: ALU_RESULT = '0;
      endcase
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int alu_ref(input int a, input int b, input int op);
      int m, sa, r;
      m = 1 << NBIT;
      case (op)
         'h20: r = a + b;
         'h21: r = a >> (b % 8);
         'h22: r = a - b + m;
         'h23: begin
            sa = (a >= m / 2) ? a - m : a;
            r  = (sa >>> (b % 8)) + m;
         end
         'h24: r = a & b;
         'h25: r = a | b;
         'h26: r = a ^ b;
         'h27: r = (m - 1) - (a | b);
         default: r = 0;
      endcase
      return r % m;
   endfunction

   function automatic logic [7:0] hex_ascii(input int n);
      if (n < 10) return 8'(48 + n);
      return 8'(65 + n - 10);
   endfunction

   // One clock: drive at the falling edge, sample just before the rising edge.
   task automatic step();
      @(negedge CLK);
      RX_EMPTY = (rx_q.size() == 0) || (rx_gaps && ($urandom_range(0, 3) == 0));
      RX_DATA  = (rx_q.size() != 0) ? rx_q[0] : 8'($urandom);
      TX_FULL  = tx_full_force || (tx_bp && ($urandom_range(0, 3) == 0));
      #4;
      cyc++;
      if (RD_RX && RX_EMPTY) rd_viol++;
      if (WR_TX && TX_FULL) wr_viol++;
      if (RD_RX && !RX_EMPTY) begin
         if (rx_q[0] == 8'h0D) cr_cyc = cyc;
         void'(rx_q.pop_front());
      end
      if (WR_TX) tx_got.push_back(TX_DATA);
      if (DONE) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (ERR) err_seen = 1'b1;
      wr_s  = WR_TX;
      txd_s = TX_DATA;
      @(posedge CLK);
   endtask

   task automatic load_str(input string s);
      line_q.delete();
      foreach (s[i]) line_q.push_back(s[i]);
      line_q.push_back(8'h0D);
   endtask

   task automatic add_num(input int v);
      string s;
      s = $sformatf("%0d", v);
      foreach (s[i]) line_q.push_back(s[i]);
   endtask

   task automatic add_sp();
      repeat ($urandom_range(0, 1)) line_q.push_back(8'h20);
   endtask

   task automatic start_line();
      foreach (line_q[i]) rx_q.push_back(line_q[i]);
      tx_got.delete();
      d0       = done_cnt;
      err_seen = 1'b0;
   endtask

   // code 0: valid expression with encoded operands ea/eb and opcode eop; else expected ERR_CODE.
   task automatic finish_line(input int code, input int ea, input int eb, input int eop);
      int   n;
      int   r;
      logic ok;
      n  = 0;
      ok = 1'b0;
      while (!ok && n < 400) begin
         step();
         #1;
         n++;
         if (code == 0) ok = (done_cnt != d0);
         else           ok = (rx_q.size() == 0) && !BUSY;
      end
      check_eq("line_finished", ok, 1);
      if (code == 0) begin
         n_done_exp++;
         r = alu_ref(ea, eb, eop);
         exp_q.delete();
         for (int k = NHEX - 1; k >= 0; k--) exp_q.push_back(hex_ascii((r >> (4 * k)) & 15));
         exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
         check_eq("alu_a", ALU_A, ea);
         check_eq("alu_b", ALU_B, eb);
         check_eq("alu_op", ALU_OP, eop);
         check_eq("err_code_after_done", ERR_CODE, 0);
         check_eq("done_once", done_cnt - d0, 1);
         check_eq("tx_len", tx_got.size(), exp_q.size());
         foreach (exp_q[i]) begin
            if (i < tx_got.size()) check_eq("tx_byte", tx_got[i], exp_q[i]);
         end
      end else begin
         check_eq("err_code", ERR_CODE, code);
         check_eq("err_seen", err_seen, 1);
         check_eq("err_released", ERR, 0);
         check_eq("no_tx_on_error", tx_got.size(), 0);
      end
   endtask

   task automatic random_line();
      int kind, na, nb, a, b, opi, code, ea, eb;
      kind = $urandom_range(0, 9);
      na   = $urandom_range(0, 1);
      nb   = $urandom_range(0, 1);
      a    = $urandom_range(0, 255);
      b    = $urandom_range(0, 255);
      opi  = $urandom_range(0, 7);
      code = 0;
      line_q.delete();
      add_sp();
      if (na != 0) line_q.push_back(8'h2D);
      case (kind)
         7: begin
            add_num(a);
            line_q.push_back(bad_ch[$urandom_range(0, 4)]);
            add_num(b);
            code = 1;
         end
         8: begin
            add_num($urandom_range(256, 999));
            line_q.push_back(op_ch[opi]);
            add_num(b);
            code = 2;
         end
         9: begin
            add_num($urandom_range(100, 255));
            line_q.push_back(8'($urandom_range(48, 57)));
            line_q.push_back(op_ch[opi]);
            add_num(b);
            code = 3;
         end
         default: begin
            add_num(a);
            add_sp();
            line_q.push_back(op_ch[opi]);
            add_sp();
            if (nb != 0) line_q.push_back(8'h2D);
            add_num(b);
            add_sp();
         end
      endcase
      line_q.push_back(8'h0D);
      ea = (na != 0) ? (256 - a) % 256 : a;
      eb = (nb != 0) ? (256 - b) % 256 : b;
      start_line();
      finish_line(code, ea, eb, 32 + opi);
   endtask

   initial begin
      int n;

      // Reset values
      RESET = 1'b1;
      repeat (3) @(negedge CLK);
      check_eq("rst_alu_a", ALU_A, 0);
      check_eq("rst_alu_b", ALU_B, 0);
      check_eq("rst_alu_op", ALU_OP, 'h20);
      check_eq("rst_busy", BUSY, 0);
      check_eq("rst_done", DONE, 0);
      check_eq("rst_err", ERR, 0);
      check_eq("rst_err_code", ERR_CODE, 0);
      check_eq("rst_wr_tx", WR_TX, 0);
      check_eq("rst_rd_rx", RD_RX, 0);
      check_eq("rst_state", dbg_state, 0);
      @(posedge CLK);
      #1 RESET = 1'b0;

      // Basic add, with latency from CR consumption to DONE
      load_str("12+34");
      start_line();
      finish_line(0, 'h0C, 'h22, 'h20);
      check_eq("latency", done_cyc - cr_cyc, NHEX + 4);

      load_str("-5 - -3");
      start_line();
      finish_line(0, 'hFB, 'hFD, 'h22);

      load_str("300+1");
      start_line();
      finish_line(2, 0, 0, 0);

      load_str("1+1");
      start_line();
      finish_line(0, 1, 1, 'h20);

      load_str("1#2");
      start_line();
      finish_line(1, 0, 0, 0);

      load_str("1234+1");
      start_line();
      finish_line(3, 0, 0, 0);

      // TX backpressure: five stalled SEND cycles
      load_str("12+34");
      start_line();
      n = 0;
      while (rx_q.size() != 0 && n < 100) begin
         step();
         n++;
      end
      tx_full_force = 1'b1;
      step();
      repeat (5) begin
         step();
         check_eq("stall_wr_tx", wr_s, 0);
         check_eq("stall_tx_data", txd_s, 8'h32);
      end
      tx_full_force = 1'b0;
      finish_line(0, 'h0C, 'h22, 'h20);
      check_eq("latency_stalled", done_cyc - cr_cyc, NHEX + 4 + 5);

      // Asynchronous reset after the first hex char is written
      load_str("12+34");
      start_line();
      n = 0;
      while (tx_got.size() < 1 && n < 100) begin
         step();
         n++;
      end
      check_eq("first_char_before_reset", tx_got.size(), 1);
      #2 RESET = 1'b1;
      #1;
      check_eq("arst_alu_a", ALU_A, 0);
      check_eq("arst_alu_b", ALU_B, 0);
      check_eq("arst_alu_op", ALU_OP, 'h20);
      check_eq("arst_busy", BUSY, 0);
      check_eq("arst_wr_tx", WR_TX, 0);
      check_eq("arst_tx_data", TX_DATA, 0);
      check_eq("arst_done", DONE, 0);
      check_eq("arst_err_code", ERR_CODE, 0);
      #1 RESET = 1'b0;
      rx_q.delete();
      load_str("7&3");
      start_line();
      finish_line(0, 7, 3, 'h24);

      // Randomized expressions with RX gaps and TX backpressure
      rx_gaps = 1'b1;
      tx_bp   = 1'b1;
      repeat (40) random_line();

      check_eq("rd_while_empty", rd_viol, 0);
      check_eq("wr_while_full", wr_viol, 0);
      check_eq("done_count", done_cnt, n_done_exp);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
